// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instr} entries between memory response and decode.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none internally; the owner guarantees no push when full and no pop when empty.
module fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    logic do_push;
    logic do_pop;

    // A clear in the same cycle wins over any push or pop.
    assign do_push = push_i & ~clr_i;
    assign do_pop  = pop_i & ~clr_i & (cnt_q != '0);

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
            end
            if (clr_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) begin
                    wr_q <= wr_q + AW'(1);
                end
                if (do_pop) begin
                    rd_q <= rd_q + AW'(1);
                end
                if (do_push && !do_pop) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (!do_push && do_pop) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign count_o    = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues in-order responses for decode, handles redirects.
// Latency: a response appears at dec_* one cycle after imem_resp_valid.
// Backpressure: requests are credit-limited so queued + outstanding never exceeds DEPTH; dec_ready stalls the queue head.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [31:0]        imem_resp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               dec_valid,
    output logic [31:0]        dec_instr,
    output logic [XLEN-1:0]    dec_pc,
    input  logic               dec_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = XLEN + INSTR_W;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   q_count;
    logic [EW-1:0]   head_dat;
    logic [CW:0]     inflight;
    logic            req_fire;
    logic            resp_keep;
    logic            deq;
    logic [XLEN-1:0] redir_pc_al;
    logic            unused_redir_low;

    // Low address bits of a redirect target are ignored: fetches are word aligned.
    assign redir_pc_al      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_low = ^redirect_pc[1:0];

    // Credit: every outstanding request owns a queue slot for its response.
    assign inflight       = {1'b0, q_count} + {1'b0, outst_q};
    assign imem_req_valid = reset & (state_q == FETCH) & (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Responses are kept only when nothing is pending drop and no redirect is flushing this cycle.
    assign resp_keep = imem_resp_valid & (drop_q == '0) & ~redirect_valid;
    assign dec_valid = (q_count != '0);
    assign deq       = dec_valid & dec_ready;
    assign dec_pc    = head_dat[EW-1:INSTR_W];
    assign dec_instr = head_dat[INSTR_W-1:0];

    fetch_queue #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (redirect_valid),
        .push_i     (resp_keep),
        .push_dat_i ({resp_pc_q, imem_resp_data}),
        .pop_i      (deq),
        .head_dat_o (head_dat),
        .count_o    (q_count)
    );

    // Next-state: PCs, credit counters and the fetch/flush mode.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
        if (resp_keep) begin
            resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
        end
        if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        if (state_q == FLUSH && drop_q == '0) begin
            state_d = FETCH;
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redir_pc_al;
            resp_pc_d  = redir_pc_al;
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? FLUSH : FETCH;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_ready       (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: memory holds accepted addresses in order; the
    // fetch and decode streams are sequential from the last reset/redirect.
    logic [31:0] pending [$];
    logic [31:0] exp_req;
    logic [31:0] exp_dec;
    int          n_req;
    logic        got_req, got_dec;
    logic [31:0] first_req_addr, first_dec_pc;
    int          pend_first;
    logic        prev_stall;
    logic [31:0] prev_addr;

    typedef struct {
        logic        rdy;
        logic        rvld;
        logic [31:0] rdat;
        logic        drdy;
        logic        e_rvld;
        logic [31:0] e_raddr;
        logic        e_dvld;
        logic [31:0] e_dpc;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_marks();
        got_req = 1'b0;
        got_dec = 1'b0;
        pend_first = -1;
        first_req_addr = 32'hFFFF_FFFF;
        first_dec_pc = 32'hFFFF_FFFF;
    endtask

    // Called at posedge+1; leaves at posedge+2 with reset released.
    task automatic do_reset();
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b0;
        pending.delete();
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_instr", dec_instr, 0);
        chk("rst_dec_pc", dec_pc, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_req = RPC;
        exp_dec = RPC;
        n_req = 0;
        prev_stall = 1'b0;
        clear_marks();
        #1;
        chk("rel_req_valid", imem_req_valid, 1);
        chk("rel_req_addr", imem_req_addr, RPC);
        chk("rel_dec_valid", dec_valid, 0);
    endtask

    // One clock of stimulus plus model bookkeeping; called at posedge+1 (or +2).
    task automatic cycle(input logic rdy, input logic drdy, input logic redir,
                         input logic [31:0] rpc, input logic resp_en);
        logic [31:0] tgt;
        imem_req_ready = rdy;
        dec_ready = drdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        if (resp_en && pending.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = instr_of(pending[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data = '0;
        end
        @(negedge clk);
        if (prev_stall) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (imem_resp_valid) void'(pending.pop_front());
        if (imem_req_valid && rdy) begin
            chk("req_addr", imem_req_addr, exp_req);
            if (!got_req) begin
                got_req = 1'b1;
                first_req_addr = imem_req_addr;
                pend_first = pending.size();
            end
            pending.push_back(imem_req_addr);
            exp_req = exp_req + 32'd4;
            n_req++;
        end
        if (dec_valid && drdy) begin
            chk("dec_pc", dec_pc, exp_dec);
            chk("dec_instr", dec_instr, instr_of(exp_dec));
            if (!got_dec) begin
                got_dec = 1'b1;
                first_dec_pc = dec_pc;
            end
            exp_dec = exp_dec + 32'd4;
        end
        if (redir) begin
            tgt = {rpc[31:2], 2'b00};
            exp_req = tgt;
            exp_dec = tgt;
        end
        chk("credit", pending.size() <= DEPTH, 1);
        prev_stall = imem_req_valid && !rdy && !redir;
        prev_addr = imem_req_addr;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        do_reset();

        // Streaming: ready=1, 1-cycle memory latency, decode always ready.
        vecs[0] = '{1, 0, 32'h0,           1, 1, 32'd0,  0, 32'd0};
        vecs[1] = '{1, 1, instr_of(32'd0),  1, 1, 32'd4,  0, 32'd0};
        vecs[2] = '{1, 1, instr_of(32'd4),  1, 1, 32'd8,  1, 32'd0};
        vecs[3] = '{1, 1, instr_of(32'd8),  1, 1, 32'd12, 1, 32'd4};
        vecs[4] = '{1, 1, instr_of(32'd12), 1, 1, 32'd16, 1, 32'd8};
        vecs[5] = '{1, 1, instr_of(32'd16), 1, 1, 32'd20, 1, 32'd12};
        vecs[6] = '{0, 1, instr_of(32'd20), 1, 1, 32'd24, 1, 32'd16};
        vecs[7] = '{0, 0, 32'h0,           0, 1, 32'd24, 1, 32'd20};
        vecs[8] = '{0, 0, 32'h0,           1, 1, 32'd24, 1, 32'd20};
        vecs[9] = '{0, 0, 32'h0,           1, 1, 32'd24, 0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            imem_req_ready = vecs[i].rdy;
            imem_resp_valid = vecs[i].rvld;
            imem_resp_data = vecs[i].rdat;
            dec_ready = vecs[i].drdy;
            redirect_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].e_rvld);
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_raddr);
            chk($sformatf("vec%0d_dec_valid", i), dec_valid, vecs[i].e_dvld);
            if (vecs[i].e_dvld) begin
                chk($sformatf("vec%0d_dec_pc", i), dec_pc, vecs[i].e_dpc);
                chk($sformatf("vec%0d_dec_instr", i), dec_instr, instr_of(vecs[i].e_dpc));
            end
            @(posedge clk); #1;
        end

        // Decode stalled: queue fills to DEPTH and fetching stops.
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 1);
        chk("fill_req_count", n_req, DEPTH);
        chk("fill_dec_valid", dec_valid, 1);
        chk("fill_dec_pc", dec_pc, 0);
        chk("fill_req_valid", imem_req_valid, 0);

        // Three outstanding, redirect to 0x100.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
        chk("flush_outstanding", pending.size(), 3);
        cycle(0, 1, 1, 32'h100, 0);
        clear_marks();
        for (int i = 0; i < 15; i++) cycle(1, 1, 0, 0, 1);
        chk("flush_first_req", first_req_addr, 32'h100);
        chk("flush_drained_first", pend_first, 0);
        chk("flush_first_dec", first_dec_pc, 32'h100);

        // Unaligned redirect target.
        do_reset();
        cycle(0, 1, 1, 32'h203, 0);
        chk("align_req_valid", imem_req_valid, 1);
        chk("align_req_addr", imem_req_addr, 32'h200);
        clear_marks();
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1);
        chk("align_first_dec", first_dec_pc, 32'h200);

        // Redirect while already flushing.
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 1, 32'h300, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 1, 32'h40, 0);
        clear_marks();
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 1);
        chk("reflush_first_req", first_req_addr, 32'h40);
        chk("reflush_drained_first", pend_first, 0);
        chk("reflush_first_dec", first_dec_pc, 32'h40);

        // Reset with two outstanding requests.
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0, 0);
        chk("midrst_outstanding", pending.size(), 2);
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
        chk("midrst_first_dec", first_dec_pc, RPC);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom,
                  $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 1);
        chk("rand_progress", n_req > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_addr  output  XLEN  fetch address, word aligned.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_resp_valid  input  1  in-order instruction return.
REQ-010 SHALL have port imem_resp_data  input  32  returned instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump/flush request.
REQ-012 SHALL have port redirect_pc  input  XLEN  new fetch PC.
REQ-013 SHALL have port dec_valid  output  1  queue head valid to decode.
REQ-014 SHALL have port dec_instr  output  32  queue head instruction.
REQ-015 SHALL have port dec_pc  output  XLEN  queue head PC.
REQ-016 SHALL have port dec_ready  input  1  decode consumes head.

Function
REQ-017 SHALL implement FSM states FETCH and FLUSH.
REQ-018 SHALL keep fetch_pc (next request address), resp_pc (PC of next accepted response), outstanding counter (0..DEPTH), drop counter, queue count.
REQ-019 SHALL assert imem_req_valid only in FETCH when count + outstanding < DEPTH; imem_req_addr = fetch_pc.
REQ-020 SHALL, on request handshake, increment fetch_pc by 4 modulo 2^XLEN and outstanding by 1.
REQ-021 SHALL hold imem_req_valid and imem_req_addr stable until accepted, except when withdrawn or changed by redirect.
REQ-022 SHALL, on imem_resp_valid with drop counter 0, push {resp_pc, imem_resp_data} into queue, increment resp_pc by 4, decrement outstanding.
REQ-023 SHALL, on imem_resp_valid with drop counter >0, discard the response and decrement both drop and outstanding.
REQ-024 SHALL drive dec_valid = (count != 0), dec_instr/dec_pc from queue head; first instruction visible one cycle after its response.
REQ-025 SHALL pop on dec_valid & dec_ready; simultaneous push and pop keeps count unchanged; full queue with response never occurs (credit rule).
REQ-026 SHALL, on redirect_valid: clear queue, set fetch_pc and resp_pc to {redirect_pc[XLEN-1:2],2'b00}, load drop counter with outstanding after this cycle's request/response updates, enter FLUSH if that value >0 else FETCH.
REQ-027 SHALL treat a decode handshake in the redirect cycle as delivered; a response in the redirect cycle is discarded; a request accepted in the redirect cycle is counted for dropping.
REQ-028 SHALL keep imem_req_valid low in FLUSH; return to FETCH the cycle after drop counter reaches 0.
REQ-029 SHALL accept redirect in FLUSH, updating PCs and reloading drop counter per REQ-026.

Reset
REQ-030 SHALL, while reset low, force state FETCH, fetch_pc = resp_pc = RESET_PC, all counters 0, queue storage 0.
REQ-031 SHALL drive during reset imem_req_valid 0, imem_req_addr RESET_PC, dec_valid 0, dec_instr 0, dec_pc 0.
REQ-032 SHALL issue the first request (addr RESET_PC) in the first cycle after reset deasserts; reset mid-operation discards all in-flight state.

Structure
REQ-033 SHALL place fetch_state_e enum, INSTR_W=32 and PC_STEP=4 in shared package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_queue (parametrised sync FIFO, width XLEN+32, depth DEPTH).

Verification
REQ-035 SHALL cover: reset release, ready=1, 1-cycle latency, dec_ready=1 -> dec_pc sequence 0,4,8,12 consecutive cycles.
REQ-036 SHALL cover: dec_ready=0, DEPTH=4 -> exactly 4 requests issued, dec_valid stays 1 with dec_pc=0, req_valid low thereafter.
REQ-037 SHALL cover: 3 outstanding, redirect to 0x100 -> 3 responses dropped, FLUSH then next request addr 0x100, first dec_pc 0x100.
REQ-038 SHALL cover: redirect_pc 0x203 -> fetch address 0x200.
REQ-039 SHALL cover: redirect during FLUSH to 0x40 -> fetch resumes at 0x40, no stale instruction reaches decode.
REQ-040 SHALL cover: reset asserted with 2 outstanding, released -> dec_valid 0, first request addr RESET_PC, stale responses never appear.
